mc_ctrl_fsm: RTL
================

# mc_ctrl_fsm

Parametrised multi-cycle control FSM for the 16-bit RISC datapath. It sequences IF/ID/EX/MEM/WB, latches the instruction register and condition flags, and drives register-file, ALU, PC and memory strobes. Unlike the first-generation controller, it handshakes with instruction and data memory through wait states, supports a watchdog timeout, and traps illegal or reserved encodings into a sticky FAULT state.

## Interface
Parameters:
- INSTR_W, 16, instruction width
- OPC_W, 4, opcode field width, taken from ir[INSTR_W-1 -: OPC_W]
- ALU_OP_W, 3, ALU operation code width
- TIMEOUT, 15, maximum wait cycles on a memory request before FAULT; must be ≥1

Ports:
- clk  in  1  clock; all state changes on its rising edge
- proc_rst_n  in  1  asynchronous, active-low reset
- imem_rdata  in  INSTR_W  fetched instruction, valid with imem_ready
- imem_ready  in  1  instruction-memory ready
- dmem_ready  in  1  data-memory ready
- carry_in, zero_in  in  1 each  ALU flags, valid in EX
- fault_clr  in  1  leave FAULT; ignored in other states
- imem_req  out  1  instruction fetch request
- dmem_req, dmem_we  out  1 each  data access request, write enable
- ir  out  INSTR_W  instruction register
- ir_write, pc_write, reg_write, alu_src  out  1 each  datapath strobes
- pc_sel  out  2  PC source: 0 = PC+1, 1 = branch target, 2 = jump target
- alu_op  out  ALU_OP_W  ALU operation
- state  out  3  current state, for debug
- fault  out  1  high in FAULT

## Operation
- States: IF, ID, EX, MEM, WB, FAULT. Outputs are combinational from state, ir and registered flags. All strobes not listed for a state are 0.
- IF: imem_req=1. On imem_ready: ir_write=1, pc_write=1, pc_sel=0, ir<=imem_rdata, then go to ID.
- ID: decode only. An unknown opcode, or cond field 11 on ADD/NAND, goes to FAULT. Otherwise go to EX.
- EX:
  - ADD (0000): alu_op=000.
  - NAND (0010): alu_op=010.
  - For both, capture carry_in/zero_in into ex_c/ex_z, then go to WB.
  - LW (1010) / SW (1001): alu_src=1, alu_op=000, then go to MEM.
  - BEQ (1011): alu_op=001. If zero_in, pc_write=1 and pc_sel=1. Go to IF.
  - JAL (1101): pc_write=1, pc_sel=2, then go to WB for the link write.
- MEM: dmem_req=1, dmem_we=1 for SW. On dmem_ready, LW goes to WB and SW goes to IF.
- WB: reg_write=1 except for ADD/NAND whose cond field is 10 with carry_flag=0, or 01 with zero_flag=0. When reg_write=1 for ADD/NAND, carry_flag<=ex_c and zero_flag<=ex_z. Go to IF.
- Condition tests use the flags from the last executed ALU instruction, never the current one.
- FAULT: fault=1, all strobes 0. fault_clr=1 goes to IF; ir and flags are kept.
- Watchdog: a counter clears on entry to IF or MEM and counts each cycle the request is unanswered. When it reaches TIMEOUT with ready=0, go to FAULT. Ready in the same cycle as the TIMEOUT count wins.

## Timing
- Reset values: state=IF, ir=0, flags=0, ex_c=ex_z=0, watchdog=0. Outputs under reset: imem_req=1, all others 0, pc_sel=0, alu_op=0, state=0.
- Reset asserted mid-operation aborts at once, dropping any dmem_req/dmem_we the same instant. Reset deassertion is taken synchronously by the next edge.
- Latency with zero wait states:
  - ADD/NAND/JAL: 4 cycles
  - LW: 5 cycles
  - SW: 4 cycles
  - BEQ: 3 cycles
- Each cycle of ready=0 in IF/MEM adds one cycle.
- Request hold rule: imem_req/dmem_req stay high and stable until the ready cycle and drop the cycle after. Ready while no request is pending is ignored.
- Strobe width: ir_write, pc_write and reg_write are exactly one cycle per instruction phase.
- Watchdog counter width is $clog2(TIMEOUT+1), saturating, with no wrap.

## Structure
- Package mc_ctrl_pkg holds:
  - opcode localparams (ADD, NAND, SW, LW, BEQ, JAL)
  - the 3-bit state encoding (IF=0, ID=1, EX=2, MEM=3, WB=4, FAULT=5)
  - alu_op codes (ADD=000, SUB=001, NAND=010)
  - pc_sel codes
- One sub-module, mc_wait_timer: inputs clear, count-enable and ready; output expired. It is instantiated once and shared by IF and MEM.

## Test plan
- ADD with cond=00, zero wait, carry_in=1 in EX → reg_write pulses in cycle 4, carry_flag=1 afterwards, pc_write only in cycle 1.
- NAND with cond=01, zero_flag=0 → WB reached but reg_write=0 and flags unchanged. Repeat with zero_flag=1 → reg_write=1.
- LW with dmem_ready held low 3 cycles → dmem_req high 4 cycles, dmem_we=0, WB in cycle 8. SW → dmem_we=1, then return to IF with no reg_write.
- BEQ with zero_in=1 → pc_write=1, pc_sel=1 in cycle 3. With zero_in=0 → no pc_write in EX.
- imem_ready low for TIMEOUT cycles → FAULT, fault=1, no strobes. fault_clr → IF next cycle. Opcode 1111 in ID → FAULT.
- proc_rst_n pulsed low during MEM of SW → dmem_req/dmem_we drop at once, state=IF, ir=0, imem_req=1.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: opcodes, FSM states,
// ALU operations, PC source selects and ADD/NAND condition codes.
package mc_ctrl_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_NAND = 4'b0010;
  localparam logic [3:0] OP_SW   = 4'b1001;
  localparam logic [3:0] OP_LW   = 4'b1010;
  localparam logic [3:0] OP_BEQ  = 4'b1011;
  localparam logic [3:0] OP_JAL  = 4'b1101;

  localparam logic [2:0] ST_IF    = 3'd0;
  localparam logic [2:0] ST_ID    = 3'd1;
  localparam logic [2:0] ST_EX    = 3'd2;
  localparam logic [2:0] ST_MEM   = 3'd3;
  localparam logic [2:0] ST_WB    = 3'd4;
  localparam logic [2:0] ST_FAULT = 3'd5;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_NAND = 3'b010;

  localparam logic [1:0] PC_INC    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  // ADD/NAND cond field in ir[1:0]
  localparam logic [1:0] COND_ALWAYS = 2'b00;
  localparam logic [1:0] COND_Z      = 2'b01;
  localparam logic [1:0] COND_C      = 2'b10;
  localparam logic [1:0] COND_RSVD   = 2'b11;

  function automatic logic opc_known(input logic [3:0] opc);
    case (opc)
      OP_ADD, OP_NAND, OP_SW, OP_LW, OP_BEQ, OP_JAL: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

  function automatic logic opc_is_alu(input logic [3:0] opc);
    return (opc == OP_ADD) || (opc == OP_NAND);
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Saturating wait-state watchdog shared by the fetch and data-memory phases.
// expired flags the TIMEOUT-th consecutive unanswered cycle; ready that cycle wins.
module mc_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic cnt_en,
  input  logic ready,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] MAX  = CW'(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)
      cnt_d = '0;
    else if (cnt_en && !ready && (cnt_q != MAX))
      cnt_d = cnt_q + 1'b1;
  end

  // cnt_q holds the unanswered cycles seen before this one
  assign expired = cnt_en && !ready && (cnt_q >= LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle IF/ID/EX/MEM/WB controller for the 16-bit RISC datapath with
// memory wait states, watchdog timeout and a sticky FAULT trap.
module mc_ctrl_fsm #(
  parameter int INSTR_W  = 16,
  parameter int OPC_W    = 4,
  parameter int ALU_OP_W = 3,
  parameter int TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                proc_rst_n,
  input  logic [INSTR_W-1:0]  imem_rdata,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  input  logic                carry_in,
  input  logic                zero_in,
  input  logic                fault_clr,
  output logic                imem_req,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [INSTR_W-1:0]  ir,
  output logic                ir_write,
  output logic                pc_write,
  output logic                reg_write,
  output logic                alu_src,
  output logic [1:0]          pc_sel,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [2:0]          state,
  output logic                fault
);
  import mc_ctrl_pkg::*;

  logic [2:0]         state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               carry_flag_q, carry_flag_d, zero_flag_q, zero_flag_d;
  logic               ex_c_q, ex_c_d, ex_z_q, ex_z_d;

  logic [3:0] opc;
  logic [1:0] cond;
  logic       alu_ins, wb_skip;
  logic       wd_clear, wd_en, wd_ready, wd_expired;

  assign opc     = 4'(ir_q[INSTR_W-1 -: OPC_W]);
  assign cond    = ir_q[1:0];
  assign alu_ins = opc_is_alu(opc);
  // Conditional ADD/NAND look only at flags committed by an earlier instruction
  assign wb_skip = alu_ins && (((cond == COND_C) && !carry_flag_q) ||
                               ((cond == COND_Z) && !zero_flag_q));

  assign wd_en    = (state_q == ST_IF) || (state_q == ST_MEM);
  assign wd_ready = (state_q == ST_MEM) ? dmem_ready : imem_ready;
  assign wd_clear = (state_d != state_q) && ((state_d == ST_IF) || (state_d == ST_MEM));

  mc_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .rst_n   (proc_rst_n),
    .clear   (wd_clear),
    .cnt_en  (wd_en),
    .ready   (wd_ready),
    .expired (wd_expired)
  );

  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    carry_flag_d = carry_flag_q;
    zero_flag_d  = zero_flag_q;
    ex_c_d       = ex_c_q;
    ex_z_d       = ex_z_q;
    imem_req     = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    reg_write    = 1'b0;
    alu_src      = 1'b0;
    pc_sel       = PC_INC;
    alu_op       = '0;
    fault        = 1'b0;
    case (state_q)
      ST_IF: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          ir_d     = imem_rdata;
          state_d  = ST_ID;
        end else if (wd_expired) begin
          state_d = ST_FAULT;
        end
      end
      ST_ID: begin
        if (!opc_known(opc) || (alu_ins && (cond == COND_RSVD))) state_d = ST_FAULT;
        else                                                    state_d = ST_EX;
      end
      ST_EX: begin
        case (opc)
          OP_ADD, OP_NAND: begin
            alu_op  = (opc == OP_NAND) ? ALU_OP_W'(ALU_NAND) : ALU_OP_W'(ALU_ADD);
            ex_c_d  = carry_in;
            ex_z_d  = zero_in;
            state_d = ST_WB;
          end
          OP_LW, OP_SW: begin
            alu_src = 1'b1;
            alu_op  = ALU_OP_W'(ALU_ADD);
            state_d = ST_MEM;
          end
          OP_BEQ: begin
            alu_op = ALU_OP_W'(ALU_SUB);
            if (zero_in) begin
              pc_write = 1'b1;
              pc_sel   = PC_BRANCH;
            end
            state_d = ST_IF;
          end
          OP_JAL: begin
            pc_write = 1'b1;
            pc_sel   = PC_JUMP;
            state_d  = ST_WB;
          end
          default: state_d = ST_FAULT;
        endcase
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (opc == OP_SW);
        if (dmem_ready)      state_d = (opc == OP_LW) ? ST_WB : ST_IF;
        else if (wd_expired) state_d = ST_FAULT;
      end
      ST_WB: begin
        reg_write = !wb_skip;
        if (alu_ins && !wb_skip) begin
          carry_flag_d = ex_c_q;
          zero_flag_d  = ex_z_q;
        end
        state_d = ST_IF;
      end
      ST_FAULT: begin
        fault = 1'b1;
        if (fault_clr) state_d = ST_IF;
      end
      default: state_d = ST_FAULT;
    endcase
  end

  always_ff @(posedge clk or negedge proc_rst_n) begin
    if (!proc_rst_n) begin
      state_q      <= ST_IF;
      ir_q         <= '0;
      carry_flag_q <= 1'b0;
      zero_flag_q  <= 1'b0;
      ex_c_q       <= 1'b0;
      ex_z_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ir_q         <= ir_d;
      carry_flag_q <= carry_flag_d;
      zero_flag_q  <= zero_flag_d;
      ex_c_q       <= ex_c_d;
      ex_z_q       <= ex_z_d;
    end
  end

  assign ir    = ir_q;
  assign state = state_q;

endmodule
